oled_serial_target: RTL and testbench

- I2C target (responder) emulating the SSD1306 write path.
- Decodes address, control, command and data bytes sent by the `serial_2wire` initiator, and ACKs accepted bytes.
- Data bytes go to an external framebuffer write port; display state is exposed as registers.
- Used as the display model in `oled_serial` benches, and as a target in FPGA-to-FPGA links.

---
 rtl/oled_pkg.sv | 50 +++++
 rtl/oled_serial_target_if.sv | 12 +
 rtl/serial_2wire_cond.sv | 36 +++
 rtl/oled_serial_target.sv | 229 ++++++++++++++++++++++
 tb/tb_oled_serial_target.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/oled_pkg.sv
// Shared constants, opcodes and FSM encoding for the SSD1306-style serial target.
package oled_pkg;

    localparam int unsigned SERIAL_BITS   = 8;
    localparam int unsigned SCREEN_WIDTH  = 128;
    localparam int unsigned SCREEN_HEIGHT = 64;
    localparam int unsigned SCREEN_PAGES  = SCREEN_HEIGHT / SERIAL_BITS;
    localparam int unsigned HCTR_BITS     = $clog2(SCREEN_WIDTH);
    localparam int unsigned PAGE_BITS     = $clog2(SCREEN_PAGES);
    localparam int unsigned BCNT_BITS     = $clog2(SERIAL_BITS);

    localparam logic [6:0] TARGET_ADDR  = 7'h3c;
    localparam logic [7:0] CONTRAST_RST = 8'h7f;

    localparam logic [7:0] OP_DISP_OFF    = 8'hae;
    localparam logic [7:0] OP_DISP_ON     = 8'haf;
    localparam logic [7:0] OP_ALL_OFF     = 8'ha4;
    localparam logic [7:0] OP_ALL_ON      = 8'ha5;
    localparam logic [7:0] OP_NORMAL      = 8'ha6;
    localparam logic [7:0] OP_INVERT      = 8'ha7;
    localparam logic [7:0] OP_CONTRAST    = 8'h81;
    localparam logic [7:0] OP_COL_ADDR    = 8'h21;
    localparam logic [7:0] OP_PAGE_ADDR   = 8'h22;
    localparam logic [7:0] OP_CLK_DIV     = 8'hd5;
    localparam logic [7:0] OP_PRECHARGE   = 8'hd9;
    localparam logic [7:0] OP_MUX_RATIO   = 8'ha8;
    localparam logic [7:0] OP_MEM_MODE    = 8'h20;
    localparam logic [7:0] OP_DISP_OFFSET = 8'hd3;
    localparam logic [7:0] OP_CHARGE_PUMP = 8'h8d;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_ACK    = 3'd2,
        ST_IGNORE = 3'd3,
        ST_CTRL   = 3'd4,
        ST_BYTE   = 3'd5
    } t_target_state;

    // Number of argument bytes that follow an opcode; unknown opcodes take none.
    function automatic logic [1:0] cmd_arg_count(input logic [7:0] op);
        case (op)
            OP_CONTRAST, OP_CLK_DIV, OP_PRECHARGE, OP_MUX_RATIO,
            OP_MEM_MODE, OP_DISP_OFFSET, OP_CHARGE_PUMP: cmd_arg_count = 2'd1;
            OP_COL_ADDR, OP_PAGE_ADDR:                   cmd_arg_count = 2'd2;
            default:                                     cmd_arg_count = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/oled_serial_target_if.sv
// Framebuffer write port driven by the serial target.
interface oled_fb_if;
    import oled_pkg::*;

    logic                   out_fb_we;
    logic [HCTR_BITS-1:0]   out_fb_x;
    logic [PAGE_BITS-1:0]   out_fb_page;
    logic [SERIAL_BITS-1:0] out_fb_data;

    modport master (output out_fb_we, output out_fb_x, output out_fb_page, output out_fb_data);
    modport slave  (input  out_fb_we, input  out_fb_x, input  out_fb_page, input  out_fb_data);
endinterface

// File: rtl/serial_2wire_cond.sv
// Two-wire bus conditioner: synchronizes SCL/SDA and emits registered edge and START/STOP pulses.
module serial_2wire_cond (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);
    // [0],[1] synchronizer stages, [2] previous synchronized value
    logic [2:0] r_scl;
    logic [2:0] r_sda;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_scl      <= 3'b111;
            r_sda      <= 3'b111;
            o_sda      <= 1'b1;
            o_scl_rise <= 1'b0;
            o_scl_fall <= 1'b0;
            o_start    <= 1'b0;
            o_stop     <= 1'b0;
        end else begin
            r_scl      <= {r_scl[1:0], i_scl};
            r_sda      <= {r_sda[1:0], i_sda};
            o_sda      <= r_sda[1];
            o_scl_rise <= r_scl[1] & ~r_scl[2];
            o_scl_fall <= ~r_scl[1] & r_scl[2];
            o_start    <= r_scl[1] & r_scl[2] & ~r_sda[1] & r_sda[2];
            o_stop     <= r_scl[1] & r_scl[2] & r_sda[1] & ~r_sda[2];
        end
    end
endmodule

// File: rtl/oled_serial_target.sv
// SSD1306 write-path emulation: address/control/command/data decode, ACK generation,
// display registers and horizontal-mode framebuffer pointer.
module oled_serial_target
    import oled_pkg::*;
(
    input  logic       in_clk,
    input  logic       in_rst,
    input  logic       in_serial_clk,
    inout  wire        inout_serial,
    oled_fb_if.master  fb,
    output logic       out_display_on,
    output logic       out_all_on,
    output logic       out_inverted,
    output logic [7:0] out_contrast,
    output logic       out_busy
);
    logic w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

    serial_2wire_cond u_cond (
        .i_clk      (in_clk),
        .i_rst      (in_rst),
        .i_scl      (in_serial_clk),
        .i_sda      (inout_serial),
        .o_sda      (w_sda),
        .o_scl_rise (w_scl_rise),
        .o_scl_fall (w_scl_fall),
        .o_start    (w_start),
        .o_stop     (w_stop)
    );

    t_target_state          r_state, w_state, r_after, w_after;
    logic                   r_ack_ph, w_ack_ph, r_sda_low, w_sda_low;
    logic [BCNT_BITS-1:0]   r_bitcnt, w_bitcnt;
    logic [SERIAL_BITS-1:0] r_shift, w_shift, w_byte;
    logic [SERIAL_BITS-1:0] r_op, w_op, r_fb_data, w_fb_data;
    logic [7:0]             r_contrast, w_contrast;
    logic [1:0]             r_args, w_args;
    logic                   r_co, w_co, r_dc, w_dc;
    logic [HCTR_BITS-1:0]   r_col_start, w_col_start, r_col_end, w_col_end, r_x, w_x;
    logic [PAGE_BITS-1:0]   r_pg_start, w_pg_start, r_pg_end, w_pg_end, r_page, w_page;
    logic                   r_fb_we, w_fb_we, r_disp_on, w_disp_on;
    logic                   r_all_on, w_all_on, r_inv, w_inv, r_busy, w_busy;

    assign inout_serial   = r_sda_low ? 1'b0 : 1'bz;
    assign fb.out_fb_we   = r_fb_we;
    assign fb.out_fb_x    = r_x;
    assign fb.out_fb_page = r_page;
    assign fb.out_fb_data = r_fb_data;
    assign out_display_on = r_disp_on;
    assign out_all_on     = r_all_on;
    assign out_inverted   = r_inv;
    assign out_contrast   = r_contrast;
    assign out_busy       = r_busy;

    // Next-state, byte decode and register updates
    always_comb begin
        w_state     = r_state;
        w_after     = r_after;
        w_ack_ph    = r_ack_ph;
        w_sda_low   = r_sda_low;
        w_bitcnt    = r_bitcnt;
        w_shift     = r_shift;
        w_op        = r_op;
        w_fb_data   = r_fb_data;
        w_contrast  = r_contrast;
        w_args      = r_args;
        w_co        = r_co;
        w_dc        = r_dc;
        w_col_start = r_col_start;
        w_col_end   = r_col_end;
        w_pg_start  = r_pg_start;
        w_pg_end    = r_pg_end;
        w_x         = r_x;
        w_page      = r_page;
        w_fb_we     = 1'b0;
        w_disp_on   = r_disp_on;
        w_all_on    = r_all_on;
        w_inv       = r_inv;
        w_busy      = r_busy;
        w_byte      = {r_shift[SERIAL_BITS-2:0], w_sda};

        // Pointer advances the cycle after the write strobe
        if (r_fb_we) begin
            if (r_x == r_col_end) begin
                w_x    = r_col_start;
                w_page = (r_page == r_pg_end) ? r_pg_start : r_page + PAGE_BITS'(1);
            end else begin
                w_x = r_x + HCTR_BITS'(1);
            end
        end

        if (w_scl_rise && (r_state inside {ST_ADDR, ST_CTRL, ST_BYTE})) begin
            w_shift  = w_byte;
            w_bitcnt = r_bitcnt + BCNT_BITS'(1);
            if (r_bitcnt == BCNT_BITS'(SERIAL_BITS - 1)) begin
                w_ack_ph = 1'b0;
                w_state  = ST_ACK;
                case (r_state)
                    ST_ADDR: begin
                        w_after = ST_CTRL;
                        if (w_byte != {TARGET_ADDR, 1'b0}) w_state = ST_IGNORE;
                    end
                    ST_CTRL: begin
                        w_co    = w_byte[7];
                        w_dc    = w_byte[6];
                        w_after = ST_BYTE;
                    end
                    default: begin
                        w_after = r_co ? ST_CTRL : ST_BYTE;
                        if (r_args != 2'd0) begin
                            w_args = r_args - 2'd1;
                            case (r_op)
                                OP_CONTRAST: w_contrast = w_byte;
                                OP_COL_ADDR:
                                    if (r_args == 2'd2) begin
                                        w_col_start = HCTR_BITS'(w_byte);
                                        w_x         = HCTR_BITS'(w_byte);
                                    end else begin
                                        w_col_end = HCTR_BITS'(w_byte);
                                    end
                                OP_PAGE_ADDR:
                                    if (r_args == 2'd2) begin
                                        w_pg_start = PAGE_BITS'(w_byte);
                                        w_page     = PAGE_BITS'(w_byte);
                                    end else begin
                                        w_pg_end = PAGE_BITS'(w_byte);
                                    end
                                default: ;
                            endcase
                        end else if (r_dc) begin
                            w_fb_we   = 1'b1;
                            w_fb_data = w_byte;
                        end else begin
                            w_op   = w_byte;
                            w_args = cmd_arg_count(w_byte);
                            case (w_byte)
                                OP_DISP_OFF: w_disp_on = 1'b0;
                                OP_DISP_ON:  w_disp_on = 1'b1;
                                OP_ALL_OFF:  w_all_on  = 1'b0;
                                OP_ALL_ON:   w_all_on  = 1'b1;
                                OP_NORMAL:   w_inv     = 1'b0;
                                OP_INVERT:   w_inv     = 1'b1;
                                default: ;
                            endcase
                        end
                    end
                endcase
            end
        end

        // ACK: pull SDA low across one full SCL low-high-low window
        if (r_state == ST_ACK && w_scl_fall) begin
            if (!r_ack_ph) begin
                w_sda_low = 1'b1;
                w_ack_ph  = 1'b1;
            end else begin
                w_sda_low = 1'b0;
                w_state   = r_after;
                w_bitcnt  = '0;
            end
        end

        if (w_start) begin
            w_state   = ST_ADDR;
            w_bitcnt  = '0;
            w_args    = 2'd0;
            w_sda_low = 1'b0;
            w_busy    = 1'b1;
        end else if (w_stop) begin
            w_state   = ST_IDLE;
            w_bitcnt  = '0;
            w_args    = 2'd0;
            w_sda_low = 1'b0;
            w_busy    = 1'b0;
        end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            r_state     <= ST_IDLE;
            r_after     <= ST_IDLE;
            r_ack_ph    <= 1'b0;
            r_sda_low   <= 1'b0;
            r_bitcnt    <= '0;
            r_shift     <= '0;
            r_op        <= '0;
            r_fb_data   <= '0;
            r_contrast  <= CONTRAST_RST;
            r_args      <= 2'd0;
            r_co        <= 1'b0;
            r_dc        <= 1'b0;
            r_col_start <= '0;
            r_col_end   <= HCTR_BITS'(SCREEN_WIDTH - 1);
            r_pg_start  <= '0;
            r_pg_end    <= PAGE_BITS'(SCREEN_PAGES - 1);
            r_x         <= '0;
            r_page      <= '0;
            r_fb_we     <= 1'b0;
            r_disp_on   <= 1'b0;
            r_all_on    <= 1'b0;
            r_inv       <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_after     <= w_after;
            r_ack_ph    <= w_ack_ph;
            r_sda_low   <= w_sda_low;
            r_bitcnt    <= w_bitcnt;
            r_shift     <= w_shift;
            r_op        <= w_op;
            r_fb_data   <= w_fb_data;
            r_contrast  <= w_contrast;
            r_args      <= w_args;
            r_co        <= w_co;
            r_dc        <= w_dc;
            r_col_start <= w_col_start;
            r_col_end   <= w_col_end;
            r_pg_start  <= w_pg_start;
            r_pg_end    <= w_pg_end;
            r_x         <= w_x;
            r_page      <= w_page;
            r_fb_we     <= w_fb_we;
            r_disp_on   <= w_disp_on;
            r_all_on    <= w_all_on;
            r_inv       <= w_inv;
            r_busy      <= w_busy;
        end
    end
endmodule

// File: tb/tb_oled_serial_target.sv
// Scoreboard bench for oled_serial_target: bit-banged two-wire initiator, ACK and framebuffer monitors.
module tb_oled_serial_target;
    import oled_pkg::*;

    localparam int unsigned Q = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl = 1'b1;
    logic sda_low = 1'b0;
    wire  sda;
    logic disp_on, all_on, inv, busy;
    logic [7:0] contrast;

    assign sda = sda_low ? 1'b0 : 1'bz;
    pullup (sda);

    oled_fb_if fb_if ();

    oled_serial_target dut (
        .in_clk         (clk),
        .in_rst         (rst),
        .in_serial_clk  (scl),
        .inout_serial   (sda),
        .fb             (fb_if),
        .out_display_on (disp_on),
        .out_all_on     (all_on),
        .out_inverted   (inv),
        .out_contrast   (contrast),
        .out_busy       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    logic [17:0] q_fb[$];
    logic        q_ack[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wq();
        repeat (Q) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        sda_low = 1'b0; wq();
        scl = 1'b1;     wq();
        sda_low = 1'b1; wq();
        scl = 1'b0;     wq();
    endtask

    task automatic i2c_stop();
        sda_low = 1'b1; wq();
        scl = 1'b1;     wq();
        sda_low = 1'b0; wq();
        wq();
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_sda"},      int'(sda), 1);
        chk({tag, "_fb_we"},    int'(fb_if.out_fb_we), 0);
        chk({tag, "_fb_x"},     int'(fb_if.out_fb_x), 0);
        chk({tag, "_fb_page"},  int'(fb_if.out_fb_page), 0);
        chk({tag, "_fb_data"},  int'(fb_if.out_fb_data), 0);
        chk({tag, "_disp_on"},  int'(disp_on), 0);
        chk({tag, "_all_on"},   int'(all_on), 0);
        chk({tag, "_inverted"}, int'(inv), 0);
        chk({tag, "_contrast"}, int'(contrast), 8'h7f);
        chk({tag, "_busy"},     int'(busy), 0);
    endtask

    // nack=1 means the target must leave SDA released in the ACK slot
    task automatic send_byte(input logic [7:0] b, input logic nack, input logic rst_in_ack);
        for (int i = 7; i >= 0; i--) begin
            sda_low = ~b[i]; wq();
            scl = 1'b1; wq(); wq();
            scl = 1'b0; wq();
        end
        q_ack.push_back(nack);
        sda_low = 1'b0; wq();
        scl = 1'b1;
        if (rst_in_ack) begin
            @(posedge clk); @(posedge clk);
            #2 rst = 1'b1;
            #1 check_reset_vals("rst_in_ack");
            wq();
            rst = 1'b0;
        end
        wq(); wq();
        scl = 1'b0; wq();
    endtask

    task automatic send(input logic [7:0] b);
        send_byte(b, 1'b0, 1'b0);
    endtask

    task automatic exp_wr(input int x, input int page, input logic [7:0] d);
        q_fb.push_back({HCTR_BITS'(x), PAGE_BITS'(page), d});
    endtask

    // ACK monitor: counts SCL rises since START, every 9th is the ACK slot
    int   mon_bits = 0;
    logic mon_scl_p = 1'b1;
    logic mon_sda_p = 1'b1;
    always @(negedge clk) begin
        if (mon_scl_p && scl && mon_sda_p && !sda) begin
            mon_bits = 0;
        end else if (!mon_scl_p && scl) begin
            mon_bits++;
            if (mon_bits == 9) begin
                mon_bits = 0;
                if (q_ack.size() == 0) chk("ack_unexpected_slot", 1, 0);
                else chk("ack_slot_sda", int'(sda), int'(q_ack.pop_front()));
            end
        end
        mon_scl_p = scl;
        mon_sda_p = sda;
    end

    // Framebuffer monitor
    always @(negedge clk) begin
        if (fb_if.out_fb_we) begin
            if (q_fb.size() == 0) begin
                chk("fb_unexpected_write", int'({fb_if.out_fb_x, fb_if.out_fb_page, fb_if.out_fb_data}), 0);
            end else begin
                logic [17:0] e;
                e = q_fb.pop_front();
                chk("fb_write_x_page_data",
                    int'({fb_if.out_fb_x, fb_if.out_fb_page, fb_if.out_fb_data}), int'(e));
            end
        end
    end

    initial begin
        repeat (200000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (4) @(posedge clk);
        #1 check_reset_vals("reset");
        rst = 1'b0;
        wq(); wq();

        // Single command with Co=1: display on
        i2c_start();
        send(8'h78);
        chk("busy_mid_transfer", int'(busy), 1);
        send(8'h80); send(8'haf);
        i2c_stop();
        chk("display_on", int'(disp_on), 1);
        chk("busy_after_stop", int'(busy), 0);

        // Read request and wrong address are NACKed; recovery on next START
        i2c_start();
        send_byte(8'h79, 1'b1, 1'b0);
        i2c_start();
        send_byte(8'h7a, 1'b1, 1'b0);
        i2c_start();
        send(8'h78); send(8'h00); send(8'ha7);
        i2c_stop();
        chk("inverted_set", int'(inv), 1);

        // Column/page window then data
        i2c_start();
        send(8'h78); send(8'h00);
        send(8'h21); send(8'h02); send(8'h03);
        send(8'h22); send(8'h01); send(8'h01);
        i2c_stop();
        i2c_start();
        send(8'h78); send(8'h40);
        exp_wr(2, 1, 8'h11); send(8'h11);
        exp_wr(3, 1, 8'h22); send(8'h22);
        exp_wr(2, 1, 8'h33); send(8'h33);
        i2c_stop();

        // Pending argument discarded by STOP
        i2c_start();
        send(8'h78); send(8'h00); send(8'h81);
        i2c_stop();
        i2c_start();
        send(8'h78); send(8'h00); send(8'ha6);
        i2c_stop();
        chk("contrast_kept", int'(contrast), 8'h7f);
        chk("a6_as_command", int'(inv), 0);

        i2c_start();
        send(8'h78); send(8'h00); send(8'h81); send(8'h20); send(8'ha5);
        i2c_stop();
        chk("contrast_set", int'(contrast), 8'h20);
        chk("all_on_set", int'(all_on), 1);

        // Co=1 interleaving of control, command and data
        i2c_start();
        send(8'h78); send(8'h80); send(8'ha4);
        send(8'hc0); exp_wr(3, 1, 8'h55); send(8'h55);
        send(8'h40);
        exp_wr(2, 1, 8'h66); send(8'h66);
        exp_wr(3, 1, 8'h77); send(8'h77);
        i2c_stop();
        chk("all_on_cleared", int'(all_on), 0);

        // Full-width row wrap on page 7
        i2c_start();
        send(8'h78); send(8'h00);
        send(8'h21); send(8'h00); send(8'h7f);
        send(8'h22); send(8'h07); send(8'h07);
        i2c_stop();
        i2c_start();
        send(8'h78); send(8'h40);
        for (int i = 0; i < 129; i++) begin
            exp_wr(i % 128, 7, 8'(i ^ 8'h5a));
            send(8'(i ^ 8'h5a));
        end
        i2c_stop();

        // Page increment and page wrap at the right edge
        i2c_start();
        send(8'h78); send(8'h00);
        send(8'h21); send(8'h7e); send(8'h7f);
        send(8'h22); send(8'h06); send(8'h07);
        i2c_stop();
        i2c_start();
        send(8'h78); send(8'h40);
        exp_wr(126, 6, 8'ha1); send(8'ha1);
        exp_wr(127, 6, 8'ha2); send(8'ha2);
        exp_wr(126, 7, 8'ha3); send(8'ha3);
        exp_wr(127, 7, 8'ha4); send(8'ha4);
        exp_wr(126, 6, 8'ha5); send(8'ha5);
        i2c_stop();

        // Reset while the target drives ACK
        i2c_start();
        send_byte(8'h78, 1'b0, 1'b1);
        i2c_start();
        send(8'h78); send(8'h40);
        exp_wr(0, 0, 8'h99); send(8'h99);
        i2c_stop();
        wq();

        chk("fb_queue_drained", q_fb.size(), 0);
        chk("ack_queue_drained", q_ack.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
